// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single data-memory port (CPU on port 0, debug/loader on port 1).
// Round-robin or fixed CPU priority with a debug starvation guard; responses return one cycle after accept.
module dmem_arbiter #(
  parameter int MODE     = 0,
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wrdata,
  input  logic [3:0]  p0_wrstb,
  output logic        p0_rsp_valid,
  output logic [31:0] p0_rsp_rddata,
  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wrdata,
  input  logic [3:0]  p1_wrstb,
  output logic        p1_rsp_valid,
  output logic [31:0] p1_rsp_rddata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wrdata,
  output logic [3:0]  mem_wrstb,
  input  logic [31:0] mem_rddata
);

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  logic        last_grant;
  logic [7:0]  wait_cnt;
  logic        pick1;
  logic        grant0;
  logic        grant1;
  logic        vld0_p1;
  logic        vld1_p1;
  logic [31:0] rdata0_p1;
  logic [31:0] rdata1_p1;

  // Stage p0: combinational arbitration and memory-side mux
  always_comb begin
    pick1 = 1'b0;
    if (MODE == 0) begin
      pick1 = ~last_grant;
    end else begin
      pick1 = (wait_cnt == WAIT_LIM);
    end
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n) begin
      if (p0_valid && p1_valid) begin
        grant0 = ~pick1;
        grant1 = pick1;
      end else begin
        grant0 = p0_valid;
        grant1 = p1_valid;
      end
    end
  end

  assign p0_ready = grant0;
  assign p1_ready = grant1;

  always_comb begin
    mem_addr   = 32'd0;
    mem_wrdata = 32'd0;
    mem_wrstb  = 4'd0;
    if (grant0) begin
      mem_addr   = p0_addr;
      mem_wrdata = p0_wrdata;
      mem_wrstb  = p0_wrstb;
    end else if (grant1) begin
      mem_addr   = p1_addr;
      mem_wrdata = p1_wrdata;
      mem_wrstb  = p1_wrstb;
    end
  end

  // Arbitration state: last_grant starts at 1 so port 0 wins the first contention
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      wait_cnt   <= 8'd0;
    end else begin
      if (grant0 || grant1) begin
        last_grant <= grant1;
      end
      if (MODE == 0) begin
        wait_cnt <= 8'd0;
      end else if (!p1_valid || grant1) begin
        wait_cnt <= 8'd0;
      end else if (wait_cnt != WAIT_LIM) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  // Stage p1: response capture, read-before-write on the accept edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld0_p1   <= 1'b0;
      vld1_p1   <= 1'b0;
      rdata0_p1 <= 32'd0;
      rdata1_p1 <= 32'd0;
    end else begin
      vld0_p1 <= grant0;
      vld1_p1 <= grant1;
      if (grant0) begin
        rdata0_p1 <= mem_rddata;
      end
      if (grant1) begin
        rdata1_p1 <= mem_rddata;
      end
    end
  end

  assign p0_rsp_valid  = vld0_p1;
  assign p0_rsp_rddata = rdata0_p1;
  assign p1_rsp_valid  = vld1_p1;
  assign p1_rsp_rddata = rdata1_p1;

endmodule
